// File: rtl/dmem_responder.sv
// Single-port word memory behind a valid/ready request/response handshake.
// One request in flight; the response appears a fixed LATENCY cycles after acceptance.
module dmem_responder #(
    parameter int unsigned DEPTH_WORDS = 256,
    parameter int unsigned LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        write_q;
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic [3:0]  wstrb_q;

    logic [31:0] mem [DEPTH_WORDS];

    logic          accept;
    logic          commit;
    logic          cur_write;
    logic [31:0]   cur_addr;
    logic [31:0]   cur_wdata;
    logic [3:0]    cur_wstrb;
    logic          cur_err;
    logic [AW-1:0] cur_idx;

    assign accept = (state_q == StIdle) && req_valid;

    // With LATENCY = 1 the access commits on the acceptance edge, so use the live request.
    always_comb begin
        cur_write = write_q;
        cur_addr  = addr_q;
        cur_wdata = wdata_q;
        cur_wstrb = wstrb_q;
        if (state_q == StIdle) begin
            cur_write = req_write;
            cur_addr  = req_addr;
            cur_wdata = req_wdata;
            cur_wstrb = req_wstrb;
        end
    end

    assign cur_err = (cur_addr[1:0] != 2'b00) || ({2'b00, cur_addr[31:2]} >= DEPTH_WORDS);
    assign cur_idx = cur_addr[AW+1:2];

    // Reset gating keeps an in-flight store from landing while reset is held.
    assign commit = !reset && ((accept && (LATENCY == 1)) ||
                               ((state_q == StWait) && (cnt_q == 4'd1)));

    always_ff @(posedge clk) begin
        if (commit && cur_write && !cur_err) begin
            for (int i = 0; i < 4; i++) begin
                if (cur_wstrb[i]) begin
                    mem[cur_idx][8*i +: 8] <= cur_wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cnt_q     <= 4'd0;
            write_q   <= 1'b0;
            addr_q    <= 32'd0;
            wdata_q   <= 32'd0;
            wstrb_q   <= 4'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (req_valid) begin
                        write_q   <= req_write;
                        addr_q    <= req_addr;
                        wdata_q   <= req_wdata;
                        wstrb_q   <= req_wstrb;
                        state_q   <= StWait;
                        cnt_q     <= 4'(LATENCY - 1);
                        req_ready <= 1'b0;
                    end
                end
                StWait: begin
                    cnt_q <= cnt_q - 4'd1;
                end
                StResp: begin
                    if (rsp_ready) begin
                        state_q   <= StIdle;
                        req_ready <= 1'b1;
                        rsp_valid <= 1'b0;
                        rsp_rdata <= 32'd0;
                        rsp_err   <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
            if (commit) begin
                state_q   <= StResp;
                cnt_q     <= 4'd0;
                req_ready <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= cur_err;
                rsp_rdata <= (!cur_err && !cur_write) ? mem[cur_idx] : 32'd0;
            end
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboarded bench for dmem_responder: a LATENCY=2 instance for the main scenarios
// and a LATENCY=1 instance for back-to-back throughput.
module tb_dmem_responder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata;
    logic [3:0]  req_wstrb;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;

    logic        req_valid1, req_ready1, req_write1;
    logic [31:0] req_addr1, req_wdata1;
    logic [3:0]  req_wstrb1;
    logic        rsp_valid1, rsp_ready1, rsp_err1;
    logic [31:0] rsp_rdata1;

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(2)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_wstrb(req_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err)
    );

    dmem_responder #(.DEPTH_WORDS(256), .LATENCY(1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid1), .req_ready(req_ready1), .req_write(req_write1),
        .req_addr(req_addr1), .req_wdata(req_wdata1), .req_wstrb(req_wstrb1),
        .rsp_valid(rsp_valid1), .rsp_ready(rsp_ready1), .rsp_rdata(rsp_rdata1),
        .rsp_err(rsp_err1)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] model [int];
    int          checks = 0;
    int          errors = 0;

    // Reference model: computes the expected response and updates the shadow memory.
    task automatic push_exp(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb);
        exp_t        e;
        logic [31:0] w;
        int          idx;
        e.err   = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'd256);
        e.rdata = 32'd0;
        if (!e.err) begin
            idx = int'(addr[31:2]);
            if (wr) begin
                if (model.exists(idx) || strb == 4'hF) begin
                    w = model.exists(idx) ? model[idx] : 32'd0;
                    for (int i = 0; i < 4; i++) if (strb[i]) w[8*i +: 8] = wdata[8*i +: 8];
                    model[idx] = w;
                end
            end else begin
                e.rdata = model.exists(idx) ? model[idx] : 32'd0;
            end
        end
        sb.push_back(e);
    endtask

    // Full transaction on the LATENCY=2 instance; caller sits #1 after a rising edge.
    task automatic do_req(input string name, input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] strb);
        int   n;
        int   lat;
        exp_t e;
        push_exp(wr, addr, wdata, strb);
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_wstrb = strb;
        n = 0;
        while (!req_ready && n < 40) begin
            @(posedge clk); #1; n++;
        end
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 1;
        while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1; lat++;
        end
        e = sb.pop_front();
        checks++;
        if (lat !== 2) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles, expected 2", name, lat);
        end
        checks++;
        if (rsp_rdata !== e.rdata) begin
            errors++;
            $display("FAIL %s rdata: got %h, expected %h", name, rsp_rdata, e.rdata);
        end
        checks++;
        if (rsp_err !== e.err) begin
            errors++;
            $display("FAIL %s err: got %b, expected %b", name, rsp_err, e.err);
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s return_idle: got valid=%b ready=%b, expected valid=0 ready=1",
                     name, rsp_valid, req_ready);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
        begin
            errors++;
            $display("FAIL reset_outputs: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_store_load();
        do_req("store_10", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF);
        do_req("load_10", 1'b0, 32'h10, 32'h0, 4'h0);
    endtask

    task automatic test_byte_strobe();
        do_req("store_20_full", 1'b1, 32'h20, 32'h11223344, 4'hF);
        do_req("store_20_strb5", 1'b1, 32'h20, 32'hAABBCCDD, 4'h5);
        do_req("load_20_merged", 1'b0, 32'h20, 32'h0, 4'h0);
        do_req("store_20_strb0", 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0);
        do_req("load_20_after_strb0", 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    task automatic test_errors();
        do_req("store_0", 1'b1, 32'h0, 32'hCAFEF00D, 4'hF);
        do_req("load_misaligned", 1'b0, 32'h22, 32'h0, 4'h0);
        do_req("load_out_of_range", 1'b0, 32'h400, 32'h0, 4'h0);
        do_req("store_out_of_range", 1'b1, 32'h400, 32'h12345678, 4'hF);
        do_req("store_misaligned_word0", 1'b1, 32'h1, 32'h0BADBAD0, 4'hF);
        do_req("load_0_unchanged", 1'b0, 32'h0, 32'h0, 4'h0);
        do_req("store_last_word", 1'b1, 32'h3FC, 32'h5A5AA5A5, 4'hF);
        do_req("load_last_word", 1'b0, 32'h3FC, 32'h0, 4'h0);
    endtask

    task automatic test_hold();
        exp_t e;
        int   n;
        push_exp(1'b0, 32'h10, 32'h0, 4'h0);
        e = sb.pop_front();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10; req_wstrb = 4'h0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 40) begin
            @(posedge clk); #1; n++;
        end
        for (int i = 0; i < 5; i++) begin
            req_valid = i[0]; req_write = 1'b1; req_addr = 32'h20; req_wdata = 32'h0;
            req_wstrb = 4'hF;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== e.rdata || rsp_err !== 1'b0 ||
                req_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_cycle%0d: got valid=%b rdata=%h err=%b ready=%b, expected 1 %h 0 0",
                         i, rsp_valid, rsp_rdata, rsp_err, req_ready, e.rdata);
            end
        end
        // Request still asserted on the consuming edge must not be taken there.
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h10;
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            errors++;
            $display("FAIL hold_release: got valid=%b ready=%b, expected valid=0 ready=1",
                     rsp_valid, req_ready);
        end
        @(posedge clk); #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL hold_no_second_accept: got ready=%b valid=%b, expected 1 0",
                     req_ready, rsp_valid);
        end
        do_req("load_20_after_hold", 1'b0, 32'h20, 32'h0, 4'h0);
    endtask

    task automatic test_reset_in_flight();
        do_req("store_30_zero", 1'b1, 32'h30, 32'h0, 4'hF);
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h30; req_wdata = 32'h55;
        req_wstrb = 4'hF;
        @(posedge clk); #1;
        req_valid = 1'b0;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL inflight_wait: got ready=%b, expected 0", req_ready);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'd0 || rsp_err !== 1'b0)
        begin
            errors++;
            $display("FAIL inflight_reset: got ready=%b valid=%b rdata=%h err=%b, expected 1 0 0 0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        do_req("load_30_after_reset", 1'b0, 32'h30, 32'h0, 4'h0);
    endtask

    task automatic test_back_to_back();
        int accepts = 0;
        req_valid1 = 1'b1; req_write1 = 1'b1; req_addr1 = 32'h40;
        req_wdata1 = 32'h12345678; req_wstrb1 = 4'hF;
        rsp_ready1 = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (req_ready1 && req_valid1) accepts++;
            @(posedge clk); #1;
            checks++;
            if (rsp_valid1 !== (k % 2 == 0) || req_ready1 !== (k % 2 != 0) ||
                (rsp_valid1 && (rsp_err1 !== 1'b0 || rsp_rdata1 !== 32'd0))) begin
                errors++;
                $display("FAIL b2b_cycle%0d: got valid=%b ready=%b err=%b rdata=%h, expected valid=%b",
                         k, rsp_valid1, req_ready1, rsp_err1, rsp_rdata1, (k % 2 == 0));
            end
        end
        req_valid1 = 1'b0;
        checks++;
        if (accepts !== 4) begin
            errors++;
            $display("FAIL b2b_accepts: got %0d, expected 4", accepts);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        reset = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = 32'd0; req_wdata = 32'd0;
        req_wstrb = 4'd0; rsp_ready = 1'b0;
        req_valid1 = 1'b0; req_write1 = 1'b0; req_addr1 = 32'd0; req_wdata1 = 32'd0;
        req_wstrb1 = 4'd0; rsp_ready1 = 1'b0;
        #1;
        test_reset();
        test_store_load();
        test_byte_strobe();
        test_errors();
        test_hold();
        test_reset_in_flight();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, number of 32-bit storage words (power of two, 4..65536).
REQ-002 SHALL have parameter LATENCY, default 2, cycles from request acceptance to first rsp_valid (1..15).
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  initiator presents a request.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request this cycle.
REQ-007 SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_addr  input  32  byte address.
REQ-009 SHALL have port req_wdata  input  32  store data.
REQ-010 SHALL have port req_wstrb  input  4  byte enables; bit i enables wdata[8i+7:8i].
REQ-011 SHALL have port rsp_valid  output  1  response available.
REQ-012 SHALL have port rsp_ready  input  1  initiator accepts the response.
REQ-013 SHALL have port rsp_rdata  output  32  load data; 0 for stores and errors.
REQ-014 SHALL have port rsp_err  output  1  access was misaligned or out of range.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 SHALL drive req_ready = 1 only in IDLE; rsp_valid = 1 only in RESP.
REQ-017 SHALL accept a request on a rising edge where req_valid && req_ready, latching write, addr, wdata, wstrb.
REQ-018 SHALL, on acceptance, go to RESP if LATENCY = 1, else to WAIT with a down-counter loaded with LATENCY-1.
REQ-019 SHALL decrement the counter each WAIT cycle and go to RESP on the edge where it would reach 0; first rsp_valid cycle is exactly LATENCY cycles after the acceptance edge.
REQ-020 SHALL flag error when addr[1:0] != 0 or addr[31:2] >= DEPTH_WORDS; word index = addr[31:2].
REQ-021 SHALL, on a non-error store, update only the enabled bytes of the addressed word on the edge entering RESP; wstrb = 0 leaves memory unchanged with rsp_err = 0.
REQ-022 SHALL, on a non-error load, capture the addressed word into rsp_rdata on the edge entering RESP.
REQ-023 SHALL, on error, perform no memory access, with rsp_rdata = 0 and rsp_err = 1.
REQ-024 SHALL hold rsp_valid, rsp_rdata, rsp_err stable in RESP until rsp_ready = 1, then return to IDLE on that edge.
REQ-025 SHALL not accept a new request in the cycle the response is consumed; next acceptance earliest one cycle later (IDLE).
REQ-026 SHALL ignore req_* inputs while in WAIT or RESP.
REQ-027 SHALL apply a load following a store to the same word after the store's response, returning the merged value.

Reset
REQ-028 SHALL, while reset = 1, force state IDLE, counter 0, req_ready = 1, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
REQ-029 SHALL discard any in-flight request on reset; a store not yet committed SHALL leave memory unchanged.
REQ-030 SHALL not initialise storage contents on reset.

Verification
REQ-031 Store addr 0x10, wdata 0xDEADBEEF, wstrb 0xF, then load 0x10 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 2 cycles after each acceptance (LATENCY = 2).
REQ-032 Store 0x11223344 to 0x20, then store 0xAABBCCDD with wstrb 0x5, load 0x20 -> 0x11BB33DD.
REQ-033 Load 0x22 (misaligned) and load 0x400 (DEPTH_WORDS = 256) -> rsp_err 1, rsp_rdata 0; storage at word 0 unchanged.
REQ-034 Hold rsp_ready = 0 for 5 cycles in RESP while toggling req_valid -> rsp_valid/rsp_rdata stable, req_ready 0, no second acceptance; rsp_ready = 1 -> IDLE next edge.
REQ-035 Assert reset during WAIT of a store of 0x55 to 0x30 (prior content 0x0) -> outputs at reset values immediately, later load 0x30 -> 0x0.
REQ-036 LATENCY = 1 build: back-to-back requests with rsp_ready tied 1 -> one accepted request every 2 cycles, rsp_valid 1 cycle after each acceptance.
